// File: rtl/mips_multicycle_ctrl_if.sv
// Sequencing bus between the multicycle controller (master) and the MIPS datapath (slave).
// No storage: pure signal bundle, latency n/a.
// Backpressure is carried by mem_ready from the memory side of the datapath.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             overflow_error;
    logic             mem_ready;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             ir_en;
    logic             iord;
    logic             memRead;
    logic             memWrite;
    logic             regWrite;
    logic             branch_en;
    logic             trap;
    logic [1:0]       exc_code;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, overflow_error, mem_ready,
        output pc_en, pc_src, ir_en, iord, memRead, memWrite, regWrite,
               branch_en, trap, exc_code, state, retired
    );

    modport slave (
        output opcode, overflow_error, mem_ready,
        input  pc_en, pc_src, ir_en, iord, memRead, memWrite, regWrite,
               branch_en, trap, exc_code, state, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer FETCH/DECODE/EXEC/MEM/WB/TRAP; optional MIPS_CTRL_OVF_TRAP_EN traps on WB overflow.
// Latency (mem_ready high): R/addi 4, lw 5, sw 4, beq 3, j 3, illegal 3 cycles to trap; outputs combinational.
// Backpressure: holds in FETCH/MEM with request asserted while mem_ready is low.
module mips_multicycle_ctrl #(
    parameter logic [31:0] VECTOR = 32'h0000_0080,
    parameter int          CNT_W  = 32
) (
    input logic                    clk,
    input logic                    reset,
    mips_multicycle_ctrl_if.master cp
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // The datapath muxes VECTOR into the PC; a misaligned vector would fetch garbage.
    if (VECTOR[1:0] != 2'b00) begin : g_vector_chk
        $error("VECTOR must be word aligned");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       exc_q, exc_d;
    logic             retire;
    logic             legal;
    logic             ovf_trap;

    logic             pc_en, ir_en, iord, mem_read, mem_write, reg_write, branch_en, trap;
    logic [1:0]       pc_src;

    assign legal = (cp.opcode == OP_RTYPE) || (cp.opcode == OP_ADDI) ||
                   (cp.opcode == OP_LW)    || (cp.opcode == OP_SW)   ||
                   (cp.opcode == OP_BEQ)   || (cp.opcode == OP_J);

`ifdef MIPS_CTRL_OVF_TRAP_EN
    assign ovf_trap = cp.overflow_error &&
                      ((cp.opcode == OP_RTYPE) || (cp.opcode == OP_ADDI));
`else
    logic unused_ovf;
    assign unused_ovf = cp.overflow_error;
    assign ovf_trap   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            exc_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            if (retire) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        exc_d     = exc_q;
        retire    = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 2'd0;
        ir_en     = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch_en = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (cp.mem_ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    exc_d   = 2'd1;
                end
            end
            S_EXEC: begin
                case (cp.opcode)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    OP_BEQ: begin
                        branch_en = 1'b1;
                        pc_src    = 2'd1;
                        retire    = 1'b1;
                    end
                    OP_J: begin
                        pc_en  = 1'b1;
                        pc_src = 2'd2;
                        retire = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                if (cp.opcode == OP_LW) begin
                    mem_read = 1'b1;
                    state_d  = cp.mem_ready ? S_WB : S_MEM;
                end else if (cp.opcode == OP_SW) begin
                    mem_write = 1'b1;
                    retire    = cp.mem_ready;
                    state_d   = cp.mem_ready ? S_FETCH : S_MEM;
                end
            end
            S_WB: begin
                if (ovf_trap) begin
                    state_d = S_TRAP;
                    exc_d   = 2'd2;
                end else begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
            end
            S_TRAP: begin
                trap   = 1'b1;
                pc_en  = 1'b1;
                pc_src = 2'd3;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an abort cannot leak a write after the reset edge.
    assign cp.pc_en     = reset & pc_en;
    assign cp.pc_src    = reset ? pc_src : 2'd0;
    assign cp.ir_en     = reset & ir_en;
    assign cp.iord      = reset & iord;
    assign cp.memRead   = reset & mem_read;
    assign cp.memWrite  = reset & mem_write;
    assign cp.regWrite  = reset & reg_write;
    assign cp.branch_en = reset & branch_en;
    assign cp.trap      = reset & trap;
    assign cp.exc_code  = exc_q;
    assign cp.state     = state_q;
    assign cp.retired   = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction phase-list model with random mem_ready stalls.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    mips_multicycle_ctrl #(.VECTOR(32'h0000_0080), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cp    (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_retired;
    logic [1:0]  exp_exc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {pc_en, pc_src, ir_en, iord, memRead, memWrite, regWrite, branch_en, trap}
    function automatic logic [9:0] strobes_obs();
        return {bus.pc_en, bus.pc_src, bus.ir_en, bus.iord, bus.memRead,
                bus.memWrite, bus.regWrite, bus.branch_en, bus.trap};
    endfunction

    function automatic logic [9:0] exp_strobes(input int ph, input logic [5:0] op,
                                               input bit mr, input bit trapping);
        logic       pce = 0, ire = 0, io = 0, rd = 0, wr = 0, rw = 0, br = 0, tr = 0;
        logic [1:0] src = 2'd0;
        case (ph)
            PH_F: begin rd = 1; if (mr) begin pce = 1; ire = 1; end end
            PH_E: begin
                if (op == OP_BEQ) begin br = 1; src = 2'd1; end
                else if (op == OP_J) begin pce = 1; src = 2'd2; end
            end
            PH_M: begin io = 1; if (op == OP_LW) rd = 1; else wr = 1; end
            PH_W: rw = !trapping;
            PH_T: begin tr = 1; pce = 1; src = 2'd3; end
            default: ;
        endcase
        return {pce, src, ire, io, rd, wr, rw, br, tr};
    endfunction

    // Runs one instruction from FETCH, checking every cycle against the phase list.
    task automatic run_instr(input logic [5:0] op, input bit ovf, input int stall_pct,
                             input int mem_lows, output int cycles, output int rw_cnt,
                             output int mw_cnt);
        int q[$];
        int idx  = 0;
        int lows = mem_lows;
        bit legal, trapping, mr;
        legal = op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        trapping = 1'b0;
`ifdef MIPS_CTRL_OVF_TRAP_EN
        trapping = ovf && (op == OP_RTYPE || op == OP_ADDI);
`endif
        q.push_back(PH_F);
        q.push_back(PH_D);
        if (!legal) begin
            q.push_back(PH_T);
        end else begin
            q.push_back(PH_E);
            if (op == OP_LW || op == OP_SW) q.push_back(PH_M);
            if (op inside {OP_RTYPE, OP_ADDI, OP_LW}) q.push_back(PH_W);
            if (trapping) q.push_back(PH_T);
        end
        bus.opcode         = op;
        bus.overflow_error = ovf;
        cycles = 0; rw_cnt = 0; mw_cnt = 0;
        while (idx < q.size()) begin
            if (q[idx] == PH_M && lows > 0) begin
                mr = 1'b0;
                lows--;
            end else begin
                mr = ($urandom_range(99) >= stall_pct);
            end
            bus.mem_ready = mr;
            @(negedge clk);
            check("state", bus.state, q[idx]);
            check("strobes", strobes_obs(), exp_strobes(q[idx], op, mr, trapping));
            check("rd_wr_excl", bus.memRead & bus.memWrite, 0);
            rw_cnt += int'(bus.regWrite);
            mw_cnt += int'(bus.memWrite);
            if (!((q[idx] == PH_F || q[idx] == PH_M) && !mr)) idx++;
            @(posedge clk);
            #1;
            cycles++;
            if (cycles > 64) begin
                check("instr_timeout", cycles, 64);
                break;
            end
        end
        if (legal && !trapping) exp_retired++;
        if (!legal) exp_exc = 2'd1;
        else if (trapping) exp_exc = 2'd2;
        check("state_end", bus.state, PH_F);
        check("retired", bus.retired, exp_retired);
        check("exc_code", bus.exc_code, exp_exc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, rw, mw, tc, trw;
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        legal_ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        bus.opcode = OP_RTYPE; bus.overflow_error = 1'b0; bus.mem_ready = 1'b1;
        exp_retired = '0; exp_exc = 2'd0;

        @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_exc", bus.exc_code, 0);
        check("rst_strobes", strobes_obs(), 0);
        @(posedge clk); #1 reset = 1'b1;

        trw = 0;
        run_instr(OP_RTYPE, 0, 0, 0, c, rw, mw); check("lat_rtype", c, 4); trw += rw;
        run_instr(OP_LW,    0, 0, 0, c, rw, mw); check("lat_lw",    c, 5); trw += rw;
        run_instr(OP_BEQ,   0, 0, 0, c, rw, mw); check("lat_beq",   c, 3); trw += rw;
        run_instr(OP_J,     0, 0, 0, c, rw, mw); check("lat_j",     c, 3); trw += rw;
        check("regwrite_cycles", trw, 2);
        check("retired_4", bus.retired, 4);

        run_instr(OP_SW, 0, 0, 3, c, rw, mw);
        check("sw_stall_lat", c, 7);
        check("sw_memwrite_cycles", mw, 4);

        run_instr(6'h3F, 0, 0, 0, c, rw, mw);
        check("illegal_lat", c, 3);
        check("illegal_exc", bus.exc_code, 1);
        check("illegal_retired", bus.retired, 5);

        run_instr(OP_ADDI, 1, 0, 0, c, rw, mw);
`ifdef MIPS_CTRL_OVF_TRAP_EN
        check("ovf_lat", c, 5);
        check("ovf_regwrite", rw, 0);
        check("ovf_exc", bus.exc_code, 2);
`else
        check("ovf_lat", c, 4);
        check("ovf_regwrite", rw, 1);
        check("ovf_retired", bus.retired, 6);
`endif

        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_retired = 32'hFFFF_FFFF;
        run_instr(OP_J, 0, 0, 0, c, rw, mw);
        check("retired_wrap", bus.retired, 0);

        // Abort a store mid-MEM with reset.
        bus.opcode = OP_SW; bus.overflow_error = 1'b0; bus.mem_ready = 1'b1;
        tc = 0;
        while (bus.state != 3'd3 && tc < 20) begin
            @(posedge clk); #1;
            tc++;
        end
        check("reach_mem", bus.state, 3);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("sw_memwrite_pre", bus.memWrite, 1);
        #2 reset = 1'b0;
        #1;
        check("async_memwrite", bus.memWrite, 0);
        check("async_state", bus.state, 0);
        check("async_retired", bus.retired, 0);
        check("async_exc", bus.exc_code, 0);
        @(posedge clk); #1;
        check("rst_strobes_hold", strobes_obs(), 0);
        reset = 1'b1;
        exp_retired = '0; exp_exc = 2'd0;
        run_instr(OP_RTYPE, 0, 0, 0, c, rw, mw);
        check("post_rst_lat", c, 4);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(9) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(5)];
            run_instr(op, 1'($urandom_range(1)), 30, 0, c, rw, mw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencing controller for the MIPS datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issues per-cycle datapath enables and the existing `regWrite`/`memWrite` strobes, and stalls on a memory ready handshake. It sits beside `controlpath` under `mips_top` and drives the datapath's sequencing inputs; `opcode` and `overflow_error` feed back from the datapath.

## Interface
- `VECTOR`, default 32'h0000_0080: PC load value on trap.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction opcode from the IR, valid from DECODE onward.
- `overflow_error` in 1: ALU signed overflow, valid in WB.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_en` out 1: PC load enable.
- `pc_src` out 2: PC source. 0 = PC+4, 1 = branch target (zero-qualified in datapath), 2 = jump target, 3 = `VECTOR`.
- `ir_en` out 1: IR load enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALU result.
- `memRead` out 1: memory read request.
- `memWrite` out 1: memory write request.
- `regWrite` out 1: register file write enable.
- `branch_en` out 1: conditional PC load on ALU zero.
- `trap` out 1: exception pulse.
- `exc_code` out 2: latched cause. 0 = none, 1 = illegal opcode, 2 = overflow.
- `state` out 3: current state encoding.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 return to FETCH on the next edge.
- Supported opcodes: R-type 6'h00, addi 6'h08, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02. Any other opcode is illegal.
- FETCH:
  - Asserts `memRead` with `iord`=0.
  - On `mem_ready`: asserts `ir_en` and `pc_en` (`pc_src`=0), moves to DECODE.
  - Otherwise holds in FETCH with outputs unchanged.
- DECODE:
  - Legal opcode: moves to EXEC.
  - Illegal opcode: moves to TRAP with `exc_code`=1.
- EXEC:
  - R-type and addi: move to WB.
  - lw and sw: move to MEM.
  - beq: asserts `branch_en` with `pc_src`=1, retires, moves to FETCH.
  - j: asserts `pc_en` with `pc_src`=2, retires, moves to FETCH.
- MEM:
  - lw: asserts `memRead` with `iord`=1. On `mem_ready`, moves to WB.
  - sw: asserts `memWrite` with `iord`=1, held until `mem_ready`. On `mem_ready`, retires and moves to FETCH.
- WB:
  - Asserts `regWrite` for exactly one cycle, retires, moves to FETCH.
  - Overflow handling is set by the configuration below.
- TRAP:
  - Asserts `trap` and `pc_en` with `pc_src`=3 for one cycle, then moves to FETCH.
  - `exc_code` holds until the next trap or reset.
- Outputs are combinational decodes of the state register, `opcode` and `mem_ready`.
- All outputs are forced to 0 while `reset` is low.
- `retired` increments by 1 on each retire edge and wraps from all-ones to 0. Trapped instructions do not retire.

## Timing
- Reset values:
  - `state`=FETCH, `retired`=0, `exc_code`=0.
  - All strobes 0 while `reset` is asserted.
- Reset asserted mid-instruction aborts it immediately. No write strobe is asserted after the reset edge.
- After deassertion, FETCH begins on the first rising edge.
- Latency with `mem_ready` tied high: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Illegal opcode takes 3 cycles to the trap (FETCH, DECODE, TRAP).
- Each low cycle of `mem_ready` adds 1 cycle in FETCH or MEM.
- `memRead` and `memWrite` are never high in the same cycle.
- `regWrite` is never high outside WB.
- `pc_en` and `ir_en` are never high while `mem_ready` is low in FETCH.

## Configuration
- `MIPS_CTRL_OVF_TRAP_EN` defined:
  - In WB, for R-type or addi with `overflow_error`=1: `regWrite` is suppressed, `exc_code`=2, next state is TRAP, no retire.
- `MIPS_CTRL_OVF_TRAP_EN` undefined:
  - `overflow_error` is ignored; `regWrite` always asserts in WB.
  - `exc_code` never takes value 2.

## Test plan
- Reset mid-MEM of sw while `memWrite`=1 → `memWrite` drops to 0 asynchronously. After release: `state`=0, `retired`=0, first FETCH on the next edge.
- R-type, then lw, then beq, then j, `mem_ready`=1 → phases last 4, 5, 3, 3 cycles; `retired`=4; `regWrite` high in exactly two cycles.
- sw with `mem_ready` low for 3 cycles in MEM → `memWrite` high for 4 consecutive cycles, `state`=3 throughout, then FETCH.
- Opcode 6'h3F → DECODE then TRAP: `trap`=1, `pc_src`=3, `exc_code`=1; `retired` unchanged.
- addi with `overflow_error`=1 in WB:
  - With `MIPS_CTRL_OVF_TRAP_EN`: `regWrite`=0, `exc_code`=2, TRAP.
  - Without it: `regWrite`=1 for one cycle, `retired`+1.
- Preload `retired`=32'hFFFF_FFFF via force, retire one instruction → `retired`=0.
